// File: rtl/cdt_pulse_player_pkg.sv
// Shared definitions for the CDT/TZX tape pulse player: command opcodes,
// FSM states and the command-word layout.
package cdt_pulse_player_pkg;

  localparam int CMD_W = 32;

  typedef enum logic [1:0] {
    OP_PULSE = 2'b00,
    OP_LEVEL = 2'b01,
    OP_PAUSE = 2'b10,
    OP_STOP  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_COUNT = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  function automatic op_e cmd_op(input logic [CMD_W-1:0] word);
    return op_e'(word[CMD_W-1:CMD_W-2]);
  endfunction

endpackage

// File: rtl/cdt_cmd_fifo.sv
// Small synchronous command FIFO with a fall-through head: rdata_o is valid
// whenever empty_o is low. Push and pop may share a clock, even when full.
module cdt_cmd_fifo #(
  parameter int W  = 32,
  parameter int AW = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2**AW];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic         do_push;
  logic         do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  // NOTE: the storage array is deliberately not reset; only the pointers are,
  // which is enough to make its contents unreachable after reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

  // NOTE: every flop is updated with <= so all state moves together on the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_q <= rd_q + {{AW{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/cdt_pulse_player.sv
// Cassette transmit path: plays timed pulse commands from a CDT loader onto
// tape_in, counting Z80 T-states via an external clock enable.
module cdt_pulse_player
  import cdt_pulse_player_pkg::*;
#(
  parameter int LEN_W   = 24,
  parameter int FIFO_AW = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce_tstate,
  input  logic             play,
  input  logic             tape_motor,
  input  logic             cmd_valid,
  input  logic [CMD_W-1:0] cmd_data,
  output logic             cmd_ready,
  output logic             tape_in,
  output logic             running,
  output logic             eot,
  output logic             underrun
);

  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [CMD_W-1:0] head;

  state_e           state_q;
  logic [LEN_W-1:0] cnt_q;
  logic             is_pulse_q;
  logic             tape_q;
  logic             eot_q;
  logic             underrun_q;
  logic             play_q;
  logic             ready_q;

  logic             tick;
  logic             expire;
  op_e              head_op;
  logic [LEN_W-1:0] head_len;
  logic [LEN_W-1:0] load_len;
  logic             unused_head;

  cdt_cmd_fifo #(
    .W  (CMD_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (cmd_data),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // ready_q keeps cmd_ready low while in reset and for no longer.
  assign cmd_ready   = ready_q & ~fifo_full;
  assign push        = cmd_valid & cmd_ready;
  assign tick        = ce_tstate & play & tape_motor;
  assign expire      = (state_q == ST_COUNT) && tick && (cnt_q == LEN_W'(1));
  assign head_op     = cmd_op(head);
  assign head_len    = head[LEN_W-1:0];
  assign load_len    = (head_len == '0) ? LEN_W'(1) : head_len;
  assign unused_head = ^head[CMD_W-3:LEN_W];

  // The head word is consumed in FETCH, or back-to-back when a count expires.
  assign pop = play & ~fifo_empty & ((state_q == ST_FETCH) | expire);

  assign tape_in  = tape_q;
  assign running  = (state_q == ST_COUNT);
  assign eot      = eot_q;
  assign underrun = underrun_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      is_pulse_q <= 1'b0;
      tape_q     <= 1'b0;
      eot_q      <= 1'b0;
      underrun_q <= 1'b0;
      play_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      play_q  <= play;
      if (play && !play_q) begin
        eot_q      <= 1'b0;
        underrun_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE:  if (play && !eot_q && !fifo_empty) state_q <= ST_FETCH;
        ST_FETCH: if (play && fifo_empty) state_q <= ST_WAIT;
        ST_COUNT: begin
          if (tick) begin
            if (cnt_q == LEN_W'(1)) begin
              if (is_pulse_q) tape_q <= ~tape_q;
              // A word arriving on the expiry clock is not an underrun.
              if (fifo_empty) begin
                state_q <= ST_WAIT;
                if (!push) underrun_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q - LEN_W'(1);
            end
          end
        end
        ST_WAIT:  if (play && !fifo_empty) state_q <= ST_FETCH;
        default:  state_q <= ST_IDLE;
      endcase

      // Decoding the popped word comes last so it overrides the state moves above.
      if (pop) begin
        case (head_op)
          OP_PULSE, OP_PAUSE: begin
            state_q    <= ST_COUNT;
            cnt_q      <= load_len;
            is_pulse_q <= (head_op == OP_PULSE);
            if (head_op == OP_PAUSE) tape_q <= 1'b0;
          end
          OP_LEVEL: begin
            state_q <= ST_FETCH;
            tape_q  <= head[0];
          end
          OP_STOP: begin
            state_q <= ST_IDLE;
            eot_q   <= 1'b1;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cdt_pulse_player.sv
// Directed bench for cdt_pulse_player: pulse timing, clock-enable gating,
// motor freeze, underrun, back-to-back streaming, STOP and async reset.
module tb_cdt_pulse_player;
  import cdt_pulse_player_pkg::*;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b0;
  logic        ce_tstate  = 1'b0;
  logic        play       = 1'b0;
  logic        tape_motor = 1'b0;
  logic        cmd_valid  = 1'b0;
  logic [31:0] cmd_data   = '0;
  logic        cmd_ready;
  logic        tape_in;
  logic        running;
  logic        eot;
  logic        underrun;

  cdt_pulse_player dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce_tstate  (ce_tstate),
    .play       (play),
    .tape_motor (tape_motor),
    .cmd_valid  (cmd_valid),
    .cmd_data   (cmd_data),
    .cmd_ready  (cmd_ready),
    .tape_in    (tape_in),
    .running    (running),
    .eot        (eot),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   ncnt   = 0;
  int   edge_n = 0;
  int   load_t = 0;
  int   edge_t [0:255];
  logic tape_prev = 1'b0;
  logic run_prev  = 1'b0;

  // Edge/load timestamps, counted in posedges, sampled just after each edge.
  always @(posedge clk) begin
    #1;
    ncnt++;
    if (tape_in !== tape_prev && edge_n < 256) begin
      edge_t[edge_n] = ncnt;
      edge_n++;
    end
    tape_prev = tape_in;
    if (running === 1'b1 && run_prev !== 1'b1) load_t = ncnt;
    run_prev = running;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input op_e op, input int len);
    logic [31:0] l;
    l = len;
    return {op, 6'd0, l[23:0]};
  endfunction

  // Called on a negedge; returns on the negedge after the accepting posedge.
  task automatic push_word(input logic [31:0] w);
    int guard = 0;
    cmd_data  = w;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("push_ready", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   t0;
    int   e0;
    logic ok;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ready", cmd_ready, 1'b0);
    check("rst_tape", tape_in, 1'b0);
    check("rst_running", running, 1'b0);
    check("rst_eot", eot, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_ready", cmd_ready, 1'b1);
    repeat (2) @(negedge clk);

    // 1: LEVEL 1, PULSE 3, PULSE 2, STOP with ce every clk
    t0 = ncnt; e0 = edge_n;
    play = 1'b1; tape_motor = 1'b1; ce_tstate = 1'b1;
    push_word(mk(OP_LEVEL, 1));
    push_word(mk(OP_PULSE, 3));
    push_word(mk(OP_PULSE, 2));
    push_word(mk(OP_STOP, 0));
    repeat (7) @(negedge clk);
    check("t1_edges", edge_n - e0, 3);
    check("t1_level_t", edge_t[e0], t0 + 3);
    check("t1_p3_t", edge_t[e0 + 1], t0 + 7);
    check("t1_p2_t", edge_t[e0 + 2], t0 + 9);
    check("t1_tape", tape_in, 1'b1);
    check("t1_underrun", underrun, 1'b0);
    check("t1_eot", eot, 1'b1);
    check("t1_running", running, 1'b0);

    // 2: ce every 4th clk, PULSE 5 loaded on a tick
    play = 1'b0;
    @(negedge clk);
    push_word(mk(OP_PULSE, 5));
    push_word(mk(OP_STOP, 0));
    t0 = ncnt; e0 = edge_n; ok = 1'b1;
    play = 1'b1;
    for (int j = 1; j <= 26; j++) begin
      ce_tstate = (j % 4 == 3);
      @(negedge clk);
      if (j >= 3 && j <= 22 && running !== 1'b1) ok = 1'b0;
    end
    ce_tstate = 1'b1;
    check("t2_eot_cleared_then_set", eot, 1'b1);
    check("t2_load_t", load_t, t0 + 3);
    check("t2_edges", edge_n - e0, 1);
    check("t2_edge_gap", edge_t[e0] - load_t, 20);
    check("t2_running_held", ok, 1'b1);
    check("t2_tape", tape_in, 1'b0);

    // 3: motor off for 37 clks during PULSE 10
    play = 1'b0;
    @(negedge clk);
    push_word(mk(OP_PULSE, 10));
    push_word(mk(OP_STOP, 0));
    t0 = ncnt; e0 = edge_n; ok = 1'b1;
    play = 1'b1;
    for (int j = 1; j <= 55; j++) begin
      tape_motor = !(j >= 6 && j <= 42);
      @(negedge clk);
      if (j >= 5 && j <= 49 && tape_in !== 1'b0) ok = 1'b0;
    end
    tape_motor = 1'b1;
    check("t3_load_t", load_t, t0 + 3);
    check("t3_edges", edge_n - e0, 1);
    check("t3_edge_gap", edge_t[e0] - load_t, 47);
    check("t3_tape_frozen", ok, 1'b1);
    check("t3_tape", tape_in, 1'b1);

    // 4: lone PULSE 2 underruns; a later push resumes; play toggle clears
    play = 1'b0;
    @(negedge clk);
    push_word(mk(OP_PULSE, 2));
    t0 = ncnt; e0 = edge_n;
    play = 1'b1;
    repeat (6) @(negedge clk);
    check("t4_underrun", underrun, 1'b1);
    check("t4_wait_running", running, 1'b0);
    check("t4_eot", eot, 1'b0);
    push_word(mk(OP_PULSE, 3));
    repeat (3) @(negedge clk);
    check("t4_resumed", running, 1'b1);
    check("t4_underrun_sticky", underrun, 1'b1);
    repeat (3) @(negedge clk);
    check("t4_edges", edge_n - e0, 2);
    check("t4_edge1_t", edge_t[e0], t0 + 5);
    check("t4_edge2_t", edge_t[e0 + 1], t0 + 12);
    play = 1'b0;
    @(negedge clk);
    play = 1'b1;
    repeat (2) @(negedge clk);
    check("t4_underrun_cleared", underrun, 1'b0);

    // 5: cmd_valid held with PULSE 0 words, then STOP
    t0 = ncnt; e0 = edge_n; ok = 1'b1;
    cmd_data = mk(OP_PULSE, 0);
    cmd_valid = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (j >= 3 && cmd_ready !== 1'b1) ok = 1'b0;
      if (j == 10) cmd_data = mk(OP_STOP, 0);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_ready_held", ok, 1'b1);
    check("t5_edges", edge_n - e0, 9);
    check("t5_first_t", edge_t[e0], t0 + 4);
    check("t5_last_t", edge_t[e0 + 8], t0 + 12);
    check("t5_eot", eot, 1'b1);
    check("t5_running", running, 1'b0);
    check("t5_tape_held", tape_in, 1'b0);

    // 5b: push lands on the expiry clock of PULSE 2
    play = 1'b0;
    @(negedge clk);
    push_word(mk(OP_PULSE, 2));
    t0 = ncnt; e0 = edge_n;
    play = 1'b1;
    repeat (4) @(negedge clk);
    cmd_data = mk(OP_PULSE, 1);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("t5b_no_underrun", underrun, 1'b0);
    check("t5b_wait", running, 1'b0);
    @(negedge clk);
    check("t5b_no_underrun2", underrun, 1'b0);
    @(negedge clk);
    check("t5b_running", running, 1'b1);
    repeat (2) @(negedge clk);
    check("t5b_edges", edge_n - e0, 2);
    check("t5b_edge1_t", edge_t[e0], t0 + 5);
    check("t5b_edge2_t", edge_t[e0 + 1], t0 + 8);
    check("t5b_late_underrun", underrun, 1'b1);

    // 6: async reset in the middle of a PAUSE
    t0 = ncnt; e0 = edge_n;
    push_word(mk(OP_LEVEL, 1));
    push_word(mk(OP_PAUSE, 20));
    push_word(mk(OP_PULSE, 5));
    check("t6_level_t", edge_t[e0], t0 + 3);
    check("t6_pause_t", edge_t[e0 + 1], t0 + 4);
    repeat (3) @(negedge clk);
    check("t6_mid_pause", running, 1'b1);
    check("t6_pre_underrun", underrun, 1'b1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_tape", tape_in, 1'b0);
    check("t6_rst_eot", eot, 1'b0);
    check("t6_rst_underrun", underrun, 1'b0);
    check("t6_rst_ready", cmd_ready, 1'b0);
    check("t6_rst_running", running, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("t6_rel_ready", cmd_ready, 1'b1);
    repeat (3) @(negedge clk);
    check("t6_fifo_empty_run", running, 1'b0);
    repeat (8) @(negedge clk);
    check("t6_fifo_empty_underrun", underrun, 1'b0);
    check("t6_tape", tape_in, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
